// File: rtl/fifo_i2s_transmitter.sv
// fifo_i2s_transmitter: drains a 32-bit Avalon-MM sample FIFO and plays each word as one 16+16 bit I2S frame
module fifo_i2s_transmitter #(
  parameter int BCLK_DIV = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear_underrun,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  output logic             i2s_bclk,
  output logic             i2s_lrclk,
  output logic             i2s_dout,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_count
);
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div_cnt;
  logic [4:0] slot;
  logic [31:0] sample_buf, shreg;
  logic buf_valid, tc, fall, load;
  assign tc = div_cnt == DW'(BCLK_DIV - 1);
  assign fall = enable && tc && i2s_bclk;
  assign load = fall && slot == 5'd0;
  // fetch state register
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_nx;
  // fetch next state: a request is held until accepted regardless of enable
  always_comb
    state_nx = state == IDLE ? ((enable && !buf_valid) ? REQ : IDLE)
             : state == REQ  ? (avm_waitrequest ? REQ : CAPT)
             : IDLE;
  // fetch outputs
  always_comb
    avm_read = state == REQ;
  // one-entry prefetch buffer; a capture beats a same-cycle load so the word survives to the next frame
  always_ff @(posedge clock)
    if (reset) buf_valid <= 1'b0;
    else if (state == CAPT) begin
      buf_valid <= 1'b1;
      sample_buf <= avm_readdata;
    end else if (load || !enable) buf_valid <= 1'b0;
  // bit clock, slot counter and serializer; shreg[31] always holds the bit due at the next falling edge
  always_ff @(posedge clock)
    if (reset || !enable) begin
      div_cnt <= '0;
      i2s_bclk <= 1'b0;
      slot <= '0;
      i2s_lrclk <= 1'b0;
      i2s_dout <= 1'b0;
      shreg <= '0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + DW'(1);
      if (tc) i2s_bclk <= !i2s_bclk;
      if (fall) begin
        slot <= slot + 5'd1;
        i2s_lrclk <= slot[4];
        i2s_dout <= shreg[31];
        shreg <= load ? (buf_valid ? sample_buf : 32'd0) : shreg << 1;
      end
    end
  // sticky underrun flag and saturating frame counter; a new underrun beats a clear
  always_ff @(posedge clock)
    if (reset) begin
      underrun <= 1'b0;
      underrun_count <= '0;
    end else if (load && !buf_valid) begin
      underrun <= 1'b1;
      underrun_count <= &underrun_count ? underrun_count : underrun_count + CNT_W'(1);
    end else if (clear_underrun) underrun <= 1'b0;
endmodule

// File: tb/tb_fifo_i2s_transmitter.sv
// tb_fifo_i2s_transmitter: random FIFO/enable stimulus checked against a frame-level model of the transmitter
module tb_fifo_i2s_transmitter;
  localparam int D = 2;
  localparam int FR = 64 * D;
  logic clock = 0, reset = 1, enable = 0, clear_underrun = 0, avm_waitrequest = 1;
  logic [31:0] avm_readdata = 0;
  logic avm_read, i2s_bclk, i2s_lrclk, i2s_dout, underrun;
  logic [15:0] underrun_count;
  int checks = 0, fails = 0, n = 0, en_n = 0, wi = 0, s;
  bit prev_read = 0, cap_next = 0, has = 0, acc, cap, e_read, ur_ev, pb;
  bit e_bclk = 0, e_lr = 0, e_dout = 0, e_ur = 0, dout_unk = 0, first_frame = 1;
  logic [31:0] cap_word = 0, buf_w = 0, frame = 0;
  logic [15:0] e_cnt = 0;

  fifo_i2s_transmitter #(.BCLK_DIV(D), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear_underrun(clear_underrun),
    .avm_read(avm_read), .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_dout(i2s_dout),
    .underrun(underrun), .underrun_count(underrun_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, act, exp, n);
    end
  endtask

  function automatic logic [31:0] next_word();
    wi++;
    return wi == 1 ? 32'hA5A50F0F : wi == 2 ? 32'h12345678 : $urandom;
  endfunction

  task automatic wait_read(input int lim);
    int k = 0;
    while (!avm_read && k < lim) begin
      @(negedge clock);
      k++;
    end
    check("read_wait", avm_read, 1);
  endtask

  // FIFO responder and frame-level reference model, evaluated just after every rising edge
  initial forever begin
    @(posedge clock);
    #1;
    n++;
    if (reset) begin
      has = 0; cap_next = 0; en_n = 0; frame = 0; first_frame = 1; dout_unk = 0;
      e_bclk = 0; e_lr = 0; e_dout = 0; e_ur = 0; e_cnt = 0;
      avm_readdata = $urandom;
      check("rst_read", avm_read, 0);
      check("rst_bclk", i2s_bclk, 0);
      check("rst_lrclk", i2s_lrclk, 0);
      check("rst_dout", i2s_dout, 0);
      check("rst_flag", underrun, 0);
      check("rst_count", underrun_count, 0);
    end else begin
      acc = prev_read && !avm_waitrequest;
      cap = cap_next;
      e_read = prev_read ? avm_waitrequest : (!cap && enable && !has);
      ur_ev = 0;
      if (enable) begin
        en_n++;
        e_bclk = (en_n / D) % 2;
        if (en_n % (2 * D) == 0) begin
          s = (en_n / (2 * D) - 1) % 32;
          e_lr = s >= 16;
          dout_unk = 0;
          if (s == 0) begin
            pb = frame[0];
            if (has) begin
              frame = buf_w;
              has = 0;
            end else begin
              frame = 0;
              ur_ev = 1;
            end
            e_dout = pb;
            dout_unk = first_frame;
            first_frame = 0;
          end else e_dout = frame[32-s];
        end
      end else begin
        en_n = 0; e_bclk = 0; e_lr = 0; e_dout = 0; dout_unk = 0;
        first_frame = 1; frame = 0; has = 0;
      end
      if (ur_ev) begin
        e_ur = 1;
        if (e_cnt != 16'hFFFF) e_cnt++;
      end else if (clear_underrun) e_ur = 0;
      if (cap) begin
        has = 1;
        buf_w = cap_word;
      end
      cap_next = acc;
      if (acc) cap_word = next_word();
      avm_readdata = acc ? cap_word : $urandom;
      check("read", avm_read, e_read);
      check("bclk", i2s_bclk, e_bclk);
      check("lrclk", i2s_lrclk, e_lr);
      if (!dout_unk) check("dout", i2s_dout, e_dout);
      check("flag", underrun, e_ur);
      check("count", underrun_count, e_cnt);
    end
    prev_read = avm_read;
  end

  // stimulus: directed scenarios followed by a randomized soak
  initial begin
    int k;
    reset = 1; enable = 1; avm_waitrequest = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    repeat (3 * FR) @(negedge clock);
    avm_waitrequest = 1;
    wait_read(4 * FR);
    repeat (20) @(negedge clock);
    avm_waitrequest = 0;
    repeat (2 * FR) @(negedge clock);
    avm_waitrequest = 1;
    repeat (4 * FR) @(negedge clock);
    check("ur_flag_set", underrun, 1);
    clear_underrun = 1;
    @(negedge clock);
    clear_underrun = 0;
    @(negedge clock);
    check("ur_flag_clr", underrun, 0);
    wait_read(4 * FR);
    k = 0;
    while (en_n % FR != 2 * D - 2 && k < 2 * FR) begin
      @(negedge clock);
      k++;
    end
    avm_waitrequest = 0;
    @(negedge clock);
    avm_waitrequest = 1;
    repeat (2 * FR) @(negedge clock);
    avm_waitrequest = 0;
    repeat (FR) @(negedge clock);
    avm_waitrequest = 1;
    wait_read(4 * FR);
    enable = 0;
    repeat (10) @(negedge clock);
    avm_waitrequest = 0;
    repeat (5) @(negedge clock);
    enable = 1;
    repeat (2 * FR) @(negedge clock);
    repeat (6000) begin
      @(negedge clock);
      avm_waitrequest = $urandom_range(2) == 0;
      clear_underrun = $urandom_range(49) == 0;
      if (enable && $urandom_range(1499) == 0) enable = 0;
      else if (!enable && $urandom_range(19) == 0) enable = 1;
    end
    clear_underrun = 0;
    enable = 1;
    avm_waitrequest = 1;
    wait_read(4 * FR);
    reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;
    avm_waitrequest = 0;
    repeat (2 * FR) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
